// File: rtl/image_mem_arbiter.sv
// ---------------------------------------------------------------------------
// image_mem_arbiter
//
// Shares one synchronous-read image memory between the processor data port
// and the VGA scan-out reader. VGA has priority. A starvation counter forces
// a CPU grant after STARVE_LIMIT consecutive VGA wins against a waiting CPU.
// At most one memory access is issued per cycle, and the read data is routed
// back one cycle later using a registered response tag.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cpu_re / cpu_we     processor read / write request (level, held to done)
//   cpu_addr            processor address, low AW bits used
//   cpu_wdata           processor store data, low DW bits written
//   cpu_rdata           last CPU read word, zero-extended
//   cpu_stall           CPU request pending and not completing this cycle
//   cpu_done            one-cycle completion pulse
//   vga_req / vga_addr  VGA read request and address
//   vga_ack             VGA request issued this cycle
//   vga_rvalid          vga_rdata valid (one cycle after vga_ack)
//   vga_rdata           VGA read data, holds last value
//   mem_*               image memory port (mem_rdata valid cycle after issue)
//   dbg_cstate          current CPU sequencer state, for checkers
//
// VGA handshake: a word is transferred on every cycle where vga_req and
// vga_ack are both high; the requester may change vga_addr after each ack.
// Its data appears on vga_rdata with vga_rvalid exactly one cycle later.
// ---------------------------------------------------------------------------
module image_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 15,
    parameter int DW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    output logic          cpu_done,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_ack,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_cstate
);

    localparam int            SW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RD   = 2'd1,
        C_DONE = 2'd2
    } cstate_t;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_VGA  = 2'd1,
        R_CPU  = 2'd2
    } owner_t;

    cstate_t       r_cstate;
    cstate_t       w_cstate_nxt;
    owner_t        r_resp_owner;
    logic [SW-1:0] r_starve_cnt;
    logic [31:0]   r_cpu_rdata;
    logic [DW-1:0] r_vga_rdata;
    logic          r_wr_done;

    logic w_cpu_req;
    logic w_cpu_pend;
    logic w_starved;
    logic w_vga_grant;
    logic w_cpu_grant;
    logic w_cpu_wr;
    logic w_cpu_rd;

    // Upper address/data bits are ignored on purpose (addresses alias).
    logic w_unused;
    assign w_unused = ^{cpu_addr[31:AW], cpu_wdata[31:DW]};

    // The request is masked in C_DONE so the processor can retire. While the
    // sequencer is busy in C_RD the request is visible (for cpu_stall) but
    // must not be granted or counted again, hence the separate pend term.
    assign w_cpu_req   = (cpu_re | cpu_we) & (r_cstate != C_DONE);
    assign w_cpu_pend  = w_cpu_req & (r_cstate == C_IDLE);
    assign w_starved   = w_cpu_pend & (r_starve_cnt == LIM);

    // Grants are suppressed while rst is held so every strobe reads 0.
    assign w_vga_grant = ~rst & vga_req & ~w_starved;
    assign w_cpu_grant = ~rst & ~w_vga_grant & w_cpu_pend;
    assign w_cpu_wr    = w_cpu_grant & cpu_we;
    assign w_cpu_rd    = w_cpu_grant & ~cpu_we;

    // State register and data/tag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cstate     <= C_IDLE;
            r_resp_owner <= R_NONE;
            r_starve_cnt <= '0;
            r_cpu_rdata  <= '0;
            r_vga_rdata  <= '0;
            r_wr_done    <= 1'b0;
        end else begin
            r_cstate  <= w_cstate_nxt;
            r_wr_done <= w_cpu_wr;

            if (w_vga_grant) begin
                r_resp_owner <= R_VGA;
            end else if (w_cpu_rd) begin
                r_resp_owner <= R_CPU;
            end else begin
                r_resp_owner <= R_NONE;
            end

            // Counts VGA wins against a waiting CPU; any other cycle clears.
            if (w_vga_grant & w_cpu_pend) begin
                if (r_starve_cnt != LIM) begin
                    r_starve_cnt <= r_starve_cnt + SW'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end

            if (r_cstate == C_RD) begin
                r_cpu_rdata <= 32'(mem_rdata);
            end
            if (r_resp_owner == R_VGA) begin
                r_vga_rdata <= mem_rdata;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        w_cstate_nxt = r_cstate;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        vga_ack      = 1'b0;
        cpu_done     = 1'b0;
        cpu_stall    = 1'b0;
        cpu_rdata    = r_cpu_rdata;
        vga_rdata    = r_vga_rdata;
        vga_rvalid   = 1'b0;

        unique case (r_cstate)
            C_IDLE: begin
                if (w_cpu_wr) begin
                    w_cstate_nxt = C_DONE;
                end else if (w_cpu_rd) begin
                    w_cstate_nxt = C_RD;
                end
            end
            C_RD:    w_cstate_nxt = C_DONE;
            C_DONE:  w_cstate_nxt = C_IDLE;
            default: w_cstate_nxt = C_IDLE;
        endcase

        // Issue stage.
        mem_en  = w_vga_grant | w_cpu_grant;
        mem_we  = w_cpu_wr;
        mem_re  = w_vga_grant | w_cpu_rd;
        vga_ack = w_vga_grant;
        if (w_vga_grant) begin
            mem_addr = vga_addr;
        end else if (w_cpu_grant) begin
            mem_addr = cpu_addr[AW-1:0];
        end
        if (w_cpu_wr) begin
            mem_wdata = cpu_wdata[DW-1:0];
        end

        // Response stage: the write done pulse lands in C_DONE, the read
        // done pulse in C_RD together with the fresh memory word.
        cpu_done = (r_cstate == C_RD) | r_wr_done;
        if (r_cstate == C_RD) begin
            cpu_rdata = 32'(mem_rdata);
        end
        if (r_resp_owner == R_VGA) begin
            vga_rvalid = 1'b1;
            vga_rdata  = mem_rdata;
        end

        cpu_stall = w_cpu_req & ~cpu_done;
    end

    assign dbg_cstate = r_cstate;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_image_mem_arbiter
//
// Drives image_mem_arbiter against a behavioural image memory. Directed
// vector table, hand-written multi-cycle sequences (streaming, starvation,
// request drop, reset during a read) and a randomized phase checked against
// a transaction-level model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_image_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int AW           = 15;
    localparam int DW           = 16;
    localparam int DEPTH        = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_re;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          cpu_done;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_ack;
    logic          vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          mem_en;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    dbg_cstate;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    image_mem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_cstate(dbg_cstate)
    );

    // ---------------- image memory (environment) ----------------
    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 37 + 1445);
    endfunction

    logic [DW-1:0] tb_mem  [DEPTH];
    bit            tb_wrtn [DEPTH];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            tb_mem[mem_addr]  <= mem_wdata;
            tb_wrtn[mem_addr] <= 1'b1;
        end
        if (mem_en && mem_re) begin
            mem_rdata <= tb_wrtn[mem_addr] ? tb_mem[mem_addr] : init_word(int'(mem_addr));
        end
    end

    // ---------------- reference state ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] vga_exp_q[$];
    logic [DW-1:0] cpu_exp_q[$];

    // ---------------- vector table ----------------
    typedef struct {
        logic          re;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          vreq;
        logic [AW-1:0] vaddr;
        logic          e_ack;
        logic          e_rvalid;
        logic          e_done;
        logic          e_stall;
        logic          e_en;
        logic          e_we;
        logic          e_re;
        logic [AW-1:0] e_maddr;
        logic          chk_cdata;
        logic [31:0]   e_cdata;
        logic          chk_vdata;
        logic [DW-1:0] e_vdata;
        logic [DW-1:0] e_mwdata;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs shortly after the rising edge, then wait until
    // the combinational outputs have settled well before the next edge.
    task automatic step(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic vr, input logic [AW-1:0] va);
        @(posedge clk);
        #2;
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        vga_req   = vr;
        vga_addr  = va;
        #4;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, '0);
    endtask

    // Watchdog: the bench is cycle-driven, this only guards against a hang.
    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int            m_starve;
        int            m_blocked;
        bit            m_done_due;
        bit            m_done_wr;
        bit            m_want;
        bit            m_vwin;
        bit            m_cwin;
        bit            p_active;
        bit            p_wr;
        bit            p_both;
        logic [31:0]   p_addr;
        logic [31:0]   p_wdata;
        logic          r_vr;
        logic [AW-1:0] r_va;
        logic [AW-1:0] exp_maddr;

        for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);

        // Reset: strobes stay low even with both requesters asserting.
        rst       = 1'b1;
        cpu_re    = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h10;
        cpu_wdata = 32'h0;
        vga_req   = 1'b1;
        vga_addr  = 15'd5;
        #7;
        chk("rst vga_ack",    vga_ack,    0);
        chk("rst mem_en",     mem_en,     0);
        chk("rst mem_re",     mem_re,     0);
        chk("rst mem_we",     mem_we,     0);
        chk("rst cpu_done",   cpu_done,   0);
        chk("rst vga_rvalid", vga_rvalid, 0);
        chk("rst cpu_rdata",  cpu_rdata,  0);
        chk("rst vga_rdata",  vga_rdata,  0);
        chk("rst cpu_stall",  cpu_stall,  1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);

        // Fields: re we addr wdata vreq vaddr | ack rvalid done stall en we re
        //         maddr | chk_cdata cdata | chk_vdata vdata | mwdata
        tbl[0] = '{1'b0, 1'b1, 32'h10, 32'h1234, 1'b0, 15'd0,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h10,
                   1'b0, 32'h0, 1'b0, 16'h0, 16'h1234};
        tbl[1] = '{1'b0, 1'b1, 32'h10, 32'h1234, 1'b0, 15'd0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0,
                   1'b0, 32'h0, 1'b0, 16'h0, 16'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 15'd0,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h10,
                   1'b0, 32'h0, 1'b0, 16'h0, 16'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 15'd0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0,
                   1'b1, 32'h1234, 1'b0, 16'h0, 16'h0};
        tbl[4] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 15'd0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0,
                   1'b1, 32'h1234, 1'b0, 16'h0, 16'h0};
        tbl[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 15'd3,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15'd3,
                   1'b1, 32'h1234, 1'b0, 16'h0, 16'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h8020, 32'h0, 1'b1, 15'd4,
                   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'd4,
                   1'b0, 32'h0, 1'b1, init_word(3), 16'h0};
        tbl[7] = '{1'b1, 1'b0, 32'h8020, 32'h0, 1'b0, 15'd0,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h20,
                   1'b0, 32'h0, 1'b1, init_word(4), 16'h0};
        tbl[8] = '{1'b1, 1'b0, 32'h8020, 32'h0, 1'b1, 15'd5,
                   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 15'd5,
                   1'b1, 32'(init_word(32)), 1'b1, init_word(4), 16'h0};
        tbl[9] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 15'd0,
                   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0,
                   1'b1, 32'(init_word(32)), 1'b1, init_word(5), 16'h0};

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].vreq, tbl[i].vaddr);
            chk($sformatf("vec%0d vga_ack", i),    vga_ack,    tbl[i].e_ack);
            chk($sformatf("vec%0d vga_rvalid", i), vga_rvalid, tbl[i].e_rvalid);
            chk($sformatf("vec%0d cpu_done", i),   cpu_done,   tbl[i].e_done);
            chk($sformatf("vec%0d cpu_stall", i),  cpu_stall,  tbl[i].e_stall);
            chk($sformatf("vec%0d mem_en", i),     mem_en,     tbl[i].e_en);
            chk($sformatf("vec%0d mem_we", i),     mem_we,     tbl[i].e_we);
            chk($sformatf("vec%0d mem_re", i),     mem_re,     tbl[i].e_re);
            if (tbl[i].e_en) chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
            if (tbl[i].e_we) chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].e_mwdata);
            if (tbl[i].chk_cdata) chk($sformatf("vec%0d cpu_rdata", i), cpu_rdata, tbl[i].e_cdata);
            if (tbl[i].chk_vdata) chk($sformatf("vec%0d vga_rdata", i), vga_rdata, tbl[i].e_vdata);
        end
        ref_mem[16] = 16'h1234;

        // VGA streaming, CPU idle: one word per cycle, data one cycle behind.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, i < 8, AW'(i));
            chk($sformatf("stream%0d vga_ack", i), vga_ack, i < 8);
            if (i < 8) chk($sformatf("stream%0d mem_addr", i), mem_addr, i);
            chk($sformatf("stream%0d vga_rvalid", i), vga_rvalid, i > 0);
            if (i > 0) chk($sformatf("stream%0d vga_rdata", i), vga_rdata, ref_mem[i-1]);
        end
        idle(2);

        // Starvation: four VGA wins, CPU forced in cycle 5, VGA again in 6.
        for (int c = 1; c <= 7; c++) begin
            step(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, AW'(100 + c));
            chk($sformatf("starve%0d vga_ack", c),   vga_ack,   c != 5);
            chk($sformatf("starve%0d cpu_done", c),  cpu_done,  c == 6);
            chk($sformatf("starve%0d cpu_stall", c), cpu_stall, c <= 5);
            if (c == 5) chk("starve5 mem_addr", mem_addr, 15'h30);
            if (c == 6) chk("starve6 cpu_rdata", cpu_rdata, 32'(ref_mem[48]));
        end
        idle(2);

        // CPU drops its request before grant: counter restarts from zero.
        for (int c = 1; c <= 9; c++) begin
            step(c != 3, 1'b0, 32'h44, 32'h0, 1'b1, AW'(200 + c));
            chk($sformatf("drop%0d vga_ack", c),  vga_ack,  c != 8);
            chk($sformatf("drop%0d cpu_done", c), cpu_done, c == 9);
            if (c == 3) chk("drop3 cpu_stall", cpu_stall, 0);
            if (c == 8) chk("drop8 mem_addr", mem_addr, 15'h44);
            if (c == 9) chk("drop9 cpu_rdata", cpu_rdata, 32'(ref_mem[68]));
        end
        idle(2);

        // Reset while the read is in flight: response is discarded.
        step(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, '0);
        chk("rstrd grant mem_re", mem_re, 1);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        vga_req = 1'b1;
        #4;
        chk("rstrd cpu_done",   cpu_done,   0);
        chk("rstrd vga_rvalid", vga_rvalid, 0);
        chk("rstrd cpu_rdata",  cpu_rdata,  0);
        chk("rstrd mem_en",     mem_en,     0);
        @(posedge clk);
        #6;
        chk("rstrd+1 cpu_done",   cpu_done,   0);
        chk("rstrd+1 vga_rvalid", vga_rvalid, 0);
        chk("rstrd+1 cpu_rdata",  cpu_rdata,  0);
        chk("rstrd+1 mem_en",     mem_en,     0);
        chk("rstrd+1 cpu_stall",  cpu_stall,  1);
        @(posedge clk);
        #2;
        rst     = 1'b0;
        cpu_re  = 1'b0;
        vga_req = 1'b0;
        idle(1);
        chk("rstrd after cpu_done", cpu_done, 0);
        chk("rstrd after vga_rvalid", vga_rvalid, 0);

        // Randomized traffic against the transaction-level model.
        m_starve   = 0;
        m_blocked  = 0;
        m_done_due = 1'b0;
        m_done_wr  = 1'b0;
        p_active   = 1'b0;
        p_wr       = 1'b0;
        p_both     = 1'b0;
        p_addr     = '0;
        p_wdata    = '0;
        for (int n = 0; n < 600; n++) begin
            if (!p_active && $urandom_range(0, 2) == 0) begin
                p_active = 1'b1;
                p_wr     = 1'($urandom_range(0, 1));
                p_both   = 1'($urandom_range(0, 1));
                p_addr   = $urandom;
                p_wdata  = $urandom;
            end
            r_vr = ($urandom_range(0, 3) != 0);
            r_va = AW'($urandom_range(0, DEPTH - 1));
            step(p_active && (!p_wr || p_both), p_active && p_wr, p_addr, p_wdata, r_vr, r_va);

            // A CPU grant is possible only outside its done/masked cycles.
            m_want = p_active && (m_blocked == 0);
            m_vwin = r_vr && !(m_want && m_starve == STARVE_LIMIT);
            m_cwin = !m_vwin && m_want;
            exp_maddr = m_vwin ? r_va : (m_cwin ? p_addr[AW-1:0] : '0);

            chk("rnd vga_ack",   vga_ack,   m_vwin);
            chk("rnd cpu_stall", cpu_stall, m_want);
            chk("rnd cpu_done",  cpu_done,  m_done_due);
            chk("rnd mem_en",    mem_en,    m_vwin || m_cwin);
            chk("rnd mem_we",    mem_we,    m_cwin && p_wr);
            chk("rnd mem_re",    mem_re,    m_vwin || (m_cwin && !p_wr));
            if (m_vwin || m_cwin) chk("rnd mem_addr", mem_addr, exp_maddr);
            if (m_cwin && p_wr) chk("rnd mem_wdata", mem_wdata, p_wdata[DW-1:0]);
            if (vga_exp_q.size() > 0) begin
                chk("rnd vga_rvalid", vga_rvalid, 1);
                chk("rnd vga_rdata", vga_rdata, vga_exp_q.pop_front());
            end else begin
                chk("rnd vga_rvalid", vga_rvalid, 0);
            end
            if (m_done_due && !m_done_wr && cpu_exp_q.size() > 0) begin
                chk("rnd cpu_rdata", cpu_rdata, 32'(cpu_exp_q.pop_front()));
            end

            if (m_vwin) vga_exp_q.push_back(ref_mem[r_va]);
            if (m_cwin) begin
                if (p_wr) ref_mem[p_addr[AW-1:0]] = p_wdata[DW-1:0];
                else      cpu_exp_q.push_back(ref_mem[p_addr[AW-1:0]]);
            end
            if (m_vwin && m_want) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
            else                  m_starve = 0;
            if (m_done_due) p_active = 1'b0;
            if (m_cwin) begin
                m_blocked = p_wr ? 1 : 2;
                m_done_wr = p_wr;
            end else if (m_blocked > 0) begin
                m_blocked--;
            end
            m_done_due = m_cwin;
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
